// File: rtl/timer_capture.sv
// timer_capture: timestamps selected edges of an async pin into a first-word fall-through FIFO.
// Optional glitch filter in front of the edge detector: define TIMER_CAPTURE_FILTER_EN.
module timer_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [1:0]                    i_edge_sel,
  input  logic                          i_cap_in,
  input  logic [31:0]                   i_cnt_value,
  output logic                          o_cap_valid,
  input  logic                          i_cap_ready,
  output logic [31:0]                   o_cap_value,
  output logic                          o_cap_edge,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr,
  output logic                          o_cap_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef TIMER_CAPTURE_FILTER_EN
  // Arming also spans the filter delay so a pin held high through reset stays silent.
  localparam int ARM_CYCLES = 3 + FILTER_LEN;
`else
  localparam int ARM_CYCLES = 3;
`endif
  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             lvl;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      arm_cnt <= '0;
    end else begin
      sync1 <= i_cap_in;
      sync2 <= sync1;
      prev  <= lvl;
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

`ifdef TIMER_CAPTURE_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FW-1:0] flt_cnt;
  logic          flt_lvl;

  // Down-counter reloads whenever sync2 agrees; the level flips on terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_lvl <= 1'b0;
      flt_cnt <= FW'(FILTER_LEN - 1);
    end else if (sync2 == flt_lvl) begin
      flt_cnt <= FW'(FILTER_LEN - 1);
    end else if (flt_cnt == '0) begin
      flt_lvl <= sync2;
      flt_cnt <= FW'(FILTER_LEN - 1);
    end else begin
      flt_cnt <= flt_cnt - FW'(1);
    end
  end

  assign lvl = flt_lvl;
`else
  assign lvl = sync2;
`endif

  logic edge_det;
  logic sel_hit;
  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  assign edge_det = armed & (lvl ^ prev);

  always_comb begin
    sel_hit = 1'b0;
    case (i_edge_sel)
      2'b00:   sel_hit = edge_det & lvl;
      2'b01:   sel_hit = edge_det & ~lvl;
      2'b10:   sel_hit = edge_det;
      default: sel_hit = 1'b0;
    endcase
  end

  assign push_req = i_en & sel_hit;

  logic [31:0]   val_mem  [FIFO_DEPTH];
  logic          edge_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  assign full        = (level == LW'(FIFO_DEPTH));
  assign o_cap_valid = (level != '0);
  assign pop         = o_cap_valid & i_cap_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push_ok     = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      val_mem[wr_ptr]  <= i_cnt_value;
      edge_mem[wr_ptr] <= lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_overflow <= 1'b0;
      o_cap_irq  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)                o_overflow <= 1'b1;
      else if (i_overflow_clr) o_overflow <= 1'b0;
      o_cap_irq <= push_ok;
    end
  end

  assign o_fifo_level = level;
  assign o_cap_value  = o_cap_valid ? val_mem[rd_ptr] : '0;
  assign o_cap_edge   = o_cap_valid & edge_mem[rd_ptr];

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
- Input-capture unit for the timer subsystem, the inverse of compare/done generation.
- It watches an asynchronous external event pin and timestamps each selected edge with the live 32-bit counter value from the timer/counter block.
- Each timestamp is queued in a small FIFO that software or an AXI4-Lite register front-end drains over a valid/ready handshake.
- Reports FIFO level, a sticky overflow flag and a per-capture interrupt pulse.

Parameters:
- FIFO_DEPTH, 4, capture FIFO entries; power of two, >= 2.
- FILTER_LEN, 3, consecutive stable cycles required by the glitch filter (only with the optional feature); >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_en  in  1  capture enable
- i_edge_sel  in  2  00 rising, 01 falling, 10 both, 11 none
- i_cap_in  in  1  asynchronous external event input
- i_cnt_value  in  32  live counter value to timestamp
- o_cap_valid  out  1  FIFO head valid (FIFO non-empty)
- i_cap_ready  in  1  consumer accepts head
- o_cap_value  out  32  timestamp at FIFO head
- o_cap_edge  out  1  head edge type: 1 rising, 0 falling
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH
- o_overflow  out  1  sticky: a capture was dropped
- i_overflow_clr  in  1  clears o_overflow
- o_cap_irq  out  1  one-cycle pulse per accepted capture

Behaviour:
- Reset values:
  - o_cap_valid=0, o_cap_value=0, o_cap_edge=0, o_fifo_level=0, o_overflow=0, o_cap_irq=0.
  - Synchronizer and previous-level registers = 0; FIFO pointers = 0.
  - Arm counter = 0.
- Synchronizer:
  - Two flops, sync1 then sync2, followed by a prev register, so the edge is detected as sync2 != prev.
  - Arm counter: edge detection is suppressed until 3 clocks after reset release. A pin held high through reset therefore never produces a spurious rising edge.
- Qualification:
  - Capture event = armed & i_en & edge matches i_edge_sel.
  - With i_edge_sel=11, no captures occur.
  - Sync and prev keep tracking while i_en=0, so enabling does not create a stale edge.
- Latency:
  - i_cap_in transition sampled at clock edge N.
  - The push occurs at edge N+2 and stores the i_cnt_value present just before edge N+2.
  - o_cap_valid and o_cap_irq are high after edge N+2.
- FIFO:
  - First-word fall-through: o_cap_value and o_cap_edge show the head combinationally from storage.
  - Pop occurs when o_cap_valid & i_cap_ready; i_cap_ready while empty has no effect.
  - Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Full boundary:
  - Push with level==FIFO_DEPTH and no pop in the same cycle: the new capture is dropped, o_overflow is set, and o_cap_irq is not pulsed.
  - Push and pop in the same cycle while full: both are accepted and there is no overflow.
- Overflow flag:
  - i_overflow_clr clears o_overflow on the next edge.
  - If a clear and a new drop happen in the same cycle, set wins.
- o_cap_irq pulses only for pushes that are accepted.
- i_en deassert:
  - Stops new captures only.
  - FIFO contents are retained and remain drainable.
- Reset mid-operation: all state returns to reset values, FIFO contents are discarded, and the arm counter restarts.

Optional Feature:
- Macro: TIMER_CAPTURE_FILTER_EN.
- Defined:
  - A digital glitch filter sits between sync2 and the edge detector.
  - The filtered level changes only after sync2 differs from it for FILTER_LEN consecutive cycles. A shorter pulse is ignored and the stability counter resets.
  - The filtered level resets to 0.
  - Total latency becomes N+2+FILTER_LEN.
- Undefined: the filter is absent, the filtered level equals sync2, FILTER_LEN is unused, and latency is N+2.

Test Plan:
- Basic rising capture: edge_sel=00, i_en=1, i_cnt_value increments from 100 each cycle, i_cap_in rises sampled at the edge where cnt=105.
  - Required: one entry with value=107 and edge=1.
  - o_cap_irq high for 1 cycle; level=1.
- Edge-type filtering:
  - edge_sel=01: a rise then a fall produce only one entry, with edge=0.
  - edge_sel=10: two entries, edge=1 then edge=0.
  - edge_sel=11: no entries.
- Overflow (FIFO_DEPTH=4, i_cap_ready=0, 6 qualifying edges):
  - Required: level=4 holding the first 4 timestamps; o_overflow=1; exactly 4 irq pulses.
  - Asserting i_overflow_clr then clears the flag.
- Full with simultaneous push and pop: FIFO full, i_cap_ready=1 in the same cycle as a new edge.
  - Required: level stays 4, o_overflow stays 0, and the oldest entry is popped.
- Reset and enable corner cases:
  - i_cap_in held high through reset release: no capture.
  - i_en=0 during an edge: no capture, existing entries still drain.
  - Reset with 3 entries held: level=0 and valid=0 after reset.
- Filter (macro defined, FILTER_LEN=3):
  - A 2-cycle high pulse yields no capture.
  - A 5-cycle pulse yields a capture with timestamp = counter at edge N+5.
